mic1_uart_rx: RTL and testbench

UART receiver for the MIC-1 SoC: deserialises the board `ser_rx` pin (8N1, LSB first) into bytes and presents them to the SoC bus side through a valid/ready stream. It sits between the top-level `ser_rx` pad and the SoC's memory-mapped serial port, complementing the SoC's transmit path on `ser_tx`. It includes an input synchroniser, a mid-bit sampling state machine, framing/overrun detection and an optional receive FIFO.

---
 rtl/mic1_uart_pkg.sv | 16 +
 rtl/mic1_uart_rx_if.sv | 28 ++
 rtl/mic1_rx_fifo.sv | 67 ++++++
 rtl/mic1_uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_mic1_uart_rx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mic1_uart_pkg.sv
// Shared definitions for the MIC-1 serial port: receiver FSM states,
// frame width and the default bit period shared with the transmitter.
package mic1_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLK_DIV   = 104;  // 12 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/mic1_uart_rx_if.sv
// Receive stream between the UART receiver (master) and the SoC serial
// port (slave): valid/ready byte stream plus error pulses.
interface mic1_uart_rx_if;
  import mic1_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/mic1_rx_fifo.sv
// Synchronous receive FIFO with a registered head word. The head register
// is refreshed on the same edge as a push into an empty queue or a pop, so
// data appears one cycle after a push and back-to-back pops drain one
// entry per cycle. Pointers carry one extra wrap bit for full/empty.
module mic1_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [WIDTH-1:0] head_q, head_n;
  logic             do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full queue is accepted only when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_n = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_n = rd_ptr + (AW+1)'(do_pop);

  // Next head word: the incoming byte if it becomes the head, else the stored entry.
  always_comb begin
    head_n = head_q;
    if (rd_ptr_n != wr_ptr_n) begin
      if (rd_ptr_n == wr_ptr) head_n = din;
      else                    head_n = mem[rd_ptr_n[AW-1:0]];
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      head_q <= head_n;
    end
  end

  // Storage write port.
  // NOTE: the storage array has no reset; which entries are live is tracked
  // entirely by the pointers, so its contents are never observed before a write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = head_q;

endmodule

// File: rtl/mic1_uart_rx.sv
// MIC-1 UART receiver: 8N1, LSB first, mid-bit sampling.
// ser_rx -> 2-flop synchroniser -> bit FSM -> byte storage -> valid/ready.
// Storage is a FIFO of FIFO_DEPTH entries when MIC1_UART_RX_FIFO_EN is
// defined, otherwise a single holding register.
module mic1_uart_rx
  import mic1_uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ser_rx,
  mic1_uart_rx_if.master rx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

  logic sync_q, rx_s;

  uart_rx_state_t            state_q, state_n;
  logic [CW-1:0]             cnt_q, cnt_n;
  logic [IW-1:0]             idx_q, idx_n;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_n;
  logic                      byte_done, stop_bad;

  logic                      pop, store_full;
  logic                      frame_err_q, overrun_q;
  logic [UART_DATA_BITS-1:0] head_data;
  logic                      head_valid;

  // Two-flop synchroniser on the pad; idles high so reset does not look like a start bit.
  // NOTE: non-blocking assignments make each stage capture the pre-edge value,
  // so the two flops stay two distinct pipeline stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= ser_rx;
      rx_s   <= sync_q;
    end
  end

  // FSM and bit datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shreg_q <= shreg_n;
    end
  end

  // Next-state logic: count down to each mid-bit sample point.
  // NOTE: every signal gets its default before the case, so no branch
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    shreg_n   = shreg_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_n = IDLE;  // too short to be a start bit
          end else begin
            cnt_n   = FULL_LOAD;
            idx_n   = '0;
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_n[idx_q] = rx_s;
          cnt_n          = FULL_LOAD;
          if (idx_q == LAST_BIT) state_n = STOP;
          else                   idx_n   = idx_q + IW'(1);
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = BREAK;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;  // wait out a held-low line
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop = head_valid && rx.rx_ready;

`ifdef MIC1_UART_RX_FIFO_EN
  logic fifo_full, fifo_empty;

  mic1_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (byte_done),
    .din   (shreg_q),
    .pop   (pop),
    .dout  (head_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_valid = !fifo_empty;
  assign store_full = fifo_full;
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;

  // Single-entry holding register; a push may replace a byte leaving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (byte_done && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= shreg_q;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign head_valid = hold_valid;
  assign head_data  = hold_data;
  assign store_full = hold_valid;
`endif

  // Error pulses, one cycle after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= byte_done && store_full && !pop;
    end
  end

  assign rx.rx_valid  = head_valid;
  assign rx.rx_data   = head_data;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;

endmodule

// File: tb/tb_mic1_uart_rx.sv
// Bench for mic1_uart_rx: directed frames on ser_rx, expected bytes queued
// at send time, a negedge monitor pops and compares on each handshake.
module tb_mic1_uart_rx;
  import mic1_uart_pkg::*;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef MIC1_UART_RX_FIFO_EN
  localparam int STORE_DEPTH = FIFO_DEPTH;
`else
  localparam int STORE_DEPTH = 1;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic ser_rx = 1'b1;

  mic1_uart_rx_if rx_if ();

  mic1_uart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_rx (ser_rx),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: counts error pulses, checks stall stability, scores handshakes.
  initial begin
    logic       stall_q;
    logic [7:0] stall_data;
    stall_q    = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_q = 1'b0;
      end else begin
        if (rx_if.frame_err) fe_cnt++;
        if (rx_if.overrun)   ov_cnt++;
        if (stall_q && rx_if.rx_valid)
          check("rx_data stable while stalled", rx_if.rx_data, stall_data);
        if (rx_if.rx_valid && rx_if.rx_ready) begin
          check("byte expected by scoreboard", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_data", rx_if.rx_data, exp_q.pop_front());
        end
        stall_q    = rx_if.rx_valid && !rx_if.rx_ready;
        stall_data = rx_if.rx_data;
      end
    end
  end

  // All line drivers start and end just after a rising edge.
  task automatic drive_bit(input logic b);
    ser_rx = b;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit expect_it);
    if (expect_it) exp_q.push_back(d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rx_if.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset rx_valid",  rx_if.rx_valid,  0);
    check("reset rx_data",   rx_if.rx_data,   0);
    check("reset frame_err", rx_if.frame_err, 0);
    check("reset overrun",   rx_if.overrun,   0);
    reset = 1'b0;
    idle(4);

    // 0x55 with start-edge to rx_valid latency: 2 sync + 1 + 8 + 9*16 cycles
    fork
      send_byte(8'h55, 1'b1, 1'b1);
      begin
        lat = 0;
        @(negedge clk);
        while (!rx_if.rx_valid && lat < 400) begin
          lat++;
          @(negedge clk);
        end
        check("rx_valid latency", lat, 155);
      end
    join
    wait_drain("0x55 delivered", 50);

    // Back-to-back frames
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1);
    wait_drain("back-to-back delivered", 50);
    check("no frame_err so far", fe_cnt, 0);
    check("no overrun so far",   ov_cnt, 0);

    // Stall: byte held until a single-cycle ready
    rx_if.rx_ready = 1'b0;
    send_byte(8'h3C, 1'b1, 1'b1);
    idle(20);
    check("rx_valid held while stalled", rx_if.rx_valid, 1);
    check("rx_data held while stalled",  rx_if.rx_data,  8'h3C);
    rx_if.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_if.rx_ready = 1'b0;
    check("rx_valid after one-cycle ready", rx_if.rx_valid, 0);
    rx_if.rx_ready = 1'b1;
    wait_drain("0x3C delivered", 10);

    // Glitch shorter than half a bit
    ser_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check("glitch rx_valid",   rx_if.rx_valid, 0);
    check("glitch frame_err",  fe_cnt, 0);
    check("glitch overrun",    ov_cnt, 0);
    send_byte(8'h81, 1'b1, 1'b1);
    wait_drain("0x81 after glitch", 50);

    // Framing error followed by a held-low line
    send_byte(8'h12, 1'b0, 1'b0);
    ser_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(20);
    check("frame_err pulse count", fe_cnt, 1);
    check("no byte on frame error", rx_if.rx_valid, 0);
    send_byte(8'h34, 1'b1, 1'b1);
    wait_drain("0x34 after frame error", 50);
    check("frame_err count after recovery", fe_cnt, 1);

    // Overrun: one byte more than storage holds
    rx_if.rx_ready = 1'b0;
    for (int i = 1; i <= STORE_DEPTH + 1; i++)
      send_byte(8'(i), 1'b1, i <= STORE_DEPTH);
    idle(10);
    check("overrun pulse count", ov_cnt, 1);
    check("head after overrun",  rx_if.rx_data, 8'h01);
    rx_if.rx_ready = 1'b1;
    wait_drain("drain after overrun", 20);
    idle(2);
    check("empty after drain", rx_if.rx_valid, 0);

    // Reset in the middle of the data bits of 0x77
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i != 3);
    ser_rx = 1'b1;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rx_valid after mid-frame reset", rx_if.rx_valid, 0);
    idle(200);
    check("no byte after mid-frame reset", rx_if.rx_valid, 0);
    check("no frame_err from reset", fe_cnt, 1);
    check("no overrun from reset",   ov_cnt, 1);
    send_byte(8'h88, 1'b1, 1'b1);
    wait_drain("0x88 after reset", 50);

    idle(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
